// File: rtl/cdu_ecntr_ctrl_if.sv
// cdu_ecntr_ctrl_if: DAC update handshake; master drives dac_code/dac_req, slave returns dac_ack
interface cdu_ecntr_ctrl_if #(parameter int CNT_W = 10);
  logic [CNT_W-1:0] dac_code;
  logic             dac_req;
  logic             dac_ack;
  modport master (output dac_code, dac_req, input dac_ack);
  modport slave  (input dac_code, dac_req, output dac_ack);
endinterface

// File: rtl/cdu_ecntr_ctrl.sv
// cdu_ecntr_ctrl: saturating CDU error counter with req/ack sequencing into the error-counter DAC
//   CLOCKH, rst_n             : AGC clock (rising edge), async active-low reset
//   AGCEEC, AGCZ, AGCCA       : active-low moding discretes (asynchronous)
//   AFpPCH, AFmPCH            : +1 / -1 count pulses (stretched levels)
//   dac                       : dac_code/dac_req out, dac_ack in
//   ecnt_en, ca_mode, sat     : mode and saturation status
//   pulse_drop                : one-cycle strobe on a pulse lost to saturation
module cdu_ecntr_ctrl #(
  parameter int CNT_W = 10,
  parameter int LIMIT = 384
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic             AGCEEC,
  input  logic             AGCZ,
  input  logic             AGCCA,
  input  logic             AFpPCH,
  input  logic             AFmPCH,
  cdu_ecntr_ctrl_if.master dac,
  output logic             ecnt_en,
  output logic             ca_mode,
  output logic             sat,
  output logic             pulse_drop
);
  typedef enum logic [1:0] {M_DIS, M_ZERO, M_ENA} mode_t;
  typedef enum logic {D_IDLE, D_REQ} dst_t;
  localparam logic signed [CNT_W-1:0] P_LIM = CNT_W'(LIMIT);
  localparam logic signed [CNT_W-1:0] N_LIM = -P_LIM;
  // bit order {AFm, AFp, CA, Z, EEC}; active-low discretes reset to their inactive level
  logic [4:0] r_s1, r_s2;
  logic [1:0] r_prev;
  logic r_pev, r_mev;
  mode_t r_mode, w_mode_nxt;
  dst_t r_dst, w_dst_nxt;
  logic signed [CNT_W-1:0] r_cnt, w_cnt_nxt, r_last, w_last_nxt, r_code, w_code_nxt;
  logic r_req, w_req_nxt, w_ena, w_inc, w_dec, w_drop;
  assign dac.dac_code = r_code;
  assign dac.dac_req  = r_req;
  assign ecnt_en      = (r_mode == M_ENA);
  // events are registered once more so a rise sampled at edge N changes the count at edge N+3
  always_ff @(posedge CLOCKH or negedge rst_n)
    if (!rst_n) begin
      r_s1   <= 5'b00111;
      r_s2   <= 5'b00111;
      r_prev <= '0;
      r_pev  <= 1'b0;
      r_mev  <= 1'b0;
    end else begin
      r_s1   <= {AFmPCH, AFpPCH, AGCCA, AGCZ, AGCEEC};
      r_s2   <= r_s1;
      r_prev <= r_s2[4:3];
      r_pev  <= r_s2[3] & ~r_prev[0];
      r_mev  <= r_s2[4] & ~r_prev[1];
    end
  always_comb w_mode_nxt = r_s2[0] ? M_DIS : (!r_s2[1] ? M_ZERO : M_ENA);
  // the count follows the mode being entered, so a forced zero lands on the same edge
  always_comb begin
    w_ena     = (w_mode_nxt == M_ENA);
    w_inc     = r_pev & ~r_mev;
    w_dec     = r_mev & ~r_pev;
    w_drop    = w_ena & ((w_inc & (r_cnt == P_LIM)) | (w_dec & (r_cnt == N_LIM)));
    w_cnt_nxt = !w_ena ? '0 :
                w_drop ? r_cnt :
                w_inc  ? r_cnt + CNT_W'(1) :
                w_dec  ? r_cnt - CNT_W'(1) : r_cnt;
  end
  always_ff @(posedge CLOCKH or negedge rst_n)
    if (!rst_n) begin
      r_mode     <= M_DIS;
      r_cnt      <= '0;
      sat        <= 1'b0;
      pulse_drop <= 1'b0;
      ca_mode    <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_cnt      <= w_cnt_nxt;
      sat        <= (w_cnt_nxt == P_LIM) || (w_cnt_nxt == N_LIM);
      pulse_drop <= w_drop;
      ca_mode    <= ~r_s2[2];
    end
  // changes arriving during D_REQ coalesce: only the latest count is sent once back in D_IDLE
  always_comb begin
    w_dst_nxt  = r_dst;
    w_code_nxt = r_code;
    w_req_nxt  = r_req;
    w_last_nxt = r_last;
    if (r_dst == D_IDLE && r_cnt != r_last) begin
      w_dst_nxt  = D_REQ;
      w_code_nxt = r_cnt;
      w_req_nxt  = 1'b1;
    end else if (r_dst == D_REQ && dac.dac_ack) begin
      w_dst_nxt  = D_IDLE;
      w_req_nxt  = 1'b0;
      w_last_nxt = r_code;
    end
  end
  always_ff @(posedge CLOCKH or negedge rst_n)
    if (!rst_n) begin
      r_dst  <= D_IDLE;
      r_code <= '0;
      r_req  <= 1'b0;
      r_last <= '0;
    end else begin
      r_dst  <= w_dst_nxt;
      r_code <= w_code_nxt;
      r_req  <= w_req_nxt;
      r_last <= w_last_nxt;
    end
endmodule

// File: doc/cdu_ecntr_ctrl.md
Name: cdu_ecntr_ctrl

Overview:
- Controller for the CDU error-counter/DAC path.
- Accepts AGC error-counter pulses (AFpPCH/AFmPCH) and the AGC moding discretes (AGCEEC, AGCZ, AGCCA).
- Maintains the signed error count with saturation, and sequences each count change into the DAC datapath over a req/ack handshake.
- Sits between the AGC interface receivers and the error-counter DAC that drives ADACH.

Parameters:
CNT_W, 10, width of signed error count and dac_code (two's complement)
LIMIT, 384, saturation magnitude; count range is -LIMIT..+LIMIT

Ports:
CLOCKH  in  1  51.2 kHz AGC clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
AGCEEC  in  1  enable error counter, active low, asynchronous to CLOCKH
AGCZ  in  1  zero CDU, active low, asynchronous
AGCCA  in  1  coarse align, active low, asynchronous
AFpPCH  in  1  error counter +1 pulse, level held high ≥1 CLOCKH period by upstream stretcher
AFmPCH  in  1  error counter -1 pulse, same rules as AFpPCH
dac_ack  in  1  DAC datapath has latched dac_code
dac_code  out  CNT_W  signed count presented to DAC
dac_req  out  1  dac_code valid, DAC update requested
ecnt_en  out  1  error counter enabled (mode ENABLED)
ca_mode  out  1  synchronized coarse-align mode, active high
sat  out  1  count at +LIMIT or -LIMIT
pulse_drop  out  1  one-cycle strobe, a pulse was discarded

Behaviour:
- Reset values: dac_code=0, dac_req=0, ecnt_en=0, ca_mode=0, sat=0, pulse_drop=0. Internal count=0, last_sent=0, DAC FSM=D_IDLE, mode=DISABLED. Reset is asynchronous.
- Synchronization: all five AGC inputs pass through 2-flop synchronizers.
  - Pulse event = rising edge of the synchronized level, so exactly one event per pulse regardless of width. Low time ≥1 period is required between pulses.
- Mode FSM, evaluated each cycle from the synchronized lines; priority order EEC, then Z:
  - DISABLED when AGCEEC=1.
  - ZEROING when AGCEEC=0 and AGCZ=0.
  - ENABLED otherwise.
  - In DISABLED and ZEROING: count forced to 0 on the next edge, all pulse events ignored without pulse_drop.
  - ecnt_en=1 only in ENABLED, registered. ca_mode = registered ~AGCCA_sync; informational only, no effect on counting.
- Counting in ENABLED:
  - +event alone: count+1. -event alone: count-1.
  - Both in the same cycle: no change, no drop.
  - Latency: AFpPCH rise sampled at edge N gives the count change visible at edge N+3.
- Saturation:
  - +event at count=+LIMIT, or -event at count=-LIMIT: count unchanged, pulse_drop=1 for one cycle.
  - sat = (count==+LIMIT) or (count==-LIMIT), registered alongside count.
  - Opposite-direction events at the limit are accepted normally.
- DAC handshake FSM, states D_IDLE and D_REQ:
  - D_IDLE: if count != last_sent, then on the next edge dac_code<=count, dac_req<=1, go to D_REQ.
  - D_REQ: dac_req and dac_code held stable. On the edge where dac_ack=1 is sampled: dac_req<=0, last_sent<=dac_code, return to D_IDLE.
  - Minimum one cycle of dac_req low between requests.
  - Count changes during D_REQ are coalesced; only the latest count is sent after return to D_IDLE. Intermediate values may never be sent.
  - dac_ack while in D_IDLE is ignored.
  - A forced zero from DISABLED/ZEROING is sequenced like any other change. If last_sent=0 already, no request is issued.
- Reset mid-handshake: dac_req drops asynchronously and the DAC datapath must abandon the transfer. After reset, count=last_sent=0, so no request is issued.
- Mode change mid-handshake: the in-flight value completes, then the zero is sent.

Test Plan:
- Reset, AGCEEC=0, AGCZ=1; 5 AFpPCH pulses 16 cycles apart, dac_ack tied high one cycle after req. Required: count reaches +5; dac_code takes values 1..5 in order; each change appears 3 edges after the sampled rise; ecnt_en=1.
- ENABLED, 390 AFpPCH pulses, immediate ack. Required: dac_code saturates at 384, sat=1; exactly 6 pulse_drop strobes; one AFmPCH then gives 383 and sat=0.
- AFpPCH and AFmPCH rising in the same cycle at count=10. Required: count stays 10, no dac_req, no pulse_drop.
- Hold dac_ack low for 40 cycles while 3 +pulses arrive from count=0. Required: dac_code=1 held stable throughout; after ack, dac_req low ≥1 cycle, then a single request with dac_code=3.
- Count=20, then AGCZ=0. Required: count=0 within 3 cycles; dac_req with dac_code=0; pulses during AGCZ=0 ignored with pulse_drop=0. Same check with AGCEEC=1, plus ecnt_en=0.
- rst_n asserted while dac_req=1 with dac_code=7. Required: all outputs 0 immediately; no dac_req after release while pulses are absent.
